// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with a valid/ready select port,
// an auto-scan mode that walks a single '1' with programmable dwell, and freeze.
module decoder_n_scan #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [SEL_W-1:0]      i_data_in,
    input  logic                  i_data_in_vld,
    output logic                  o_data_in_rdy,
    input  logic                  i_data_in_en,
    input  logic [1:0]            i_mode,
    input  logic [DWELL_W-1:0]    i_dwell,
    output logic [(2**SEL_W)-1:0] decoder_out,
    output logic [SEL_W-1:0]      o_index,
    output logic                  o_wrap
);

    localparam int OUT_W = 2**SEL_W;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECODE = 2'b01,
        SCAN   = 2'b10,
        FREEZE = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   index, index_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic               wrap_nxt;
    logic               rdy;
    logic               en_r;

    logic               accept;
    logic               scan_mode;
    logic [DWELL_W-1:0] dwell_m1;
    logic               term;

    assign accept    = i_data_in_vld & rdy;
    assign scan_mode = (i_mode == MODE_UP) || (i_mode == MODE_DOWN);
    // A dwell of 0 behaves like 1; compared live so a shrinking dwell still terminates.
    assign dwell_m1  = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
    assign term      = (cnt >= dwell_m1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            index  <= '0;
            cnt    <= '0;
            o_wrap <= 1'b0;
            rdy    <= 1'b0;
            en_r   <= 1'b0;
        end else begin
            state  <= state_nxt;
            index  <= index_nxt;
            cnt    <= cnt_nxt;
            o_wrap <= wrap_nxt;
            rdy    <= (state_nxt != FREEZE);
            en_r   <= i_data_in_en;
        end
    end

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        cnt_nxt   = cnt;
        wrap_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_mode == MODE_DIRECT) begin
                    if (accept) begin
                        state_nxt = DECODE;
                        index_nxt = i_data_in;
                    end
                end else if (scan_mode) begin
                    state_nxt = SCAN;
                    index_nxt = accept ? i_data_in : '0;
                    cnt_nxt   = '0;
                end
            end
            DECODE: begin
                if (accept) index_nxt = i_data_in;
                if (scan_mode) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end else if (i_mode != MODE_DIRECT) begin
                    state_nxt = FREEZE;
                end
            end
            SCAN: begin
                if (i_mode == MODE_DIRECT) begin
                    state_nxt = DECODE;
                    cnt_nxt   = '0;
                    if (accept) index_nxt = i_data_in;
                end else if (!scan_mode) begin
                    state_nxt = FREEZE;
                    if (accept) index_nxt = i_data_in;
                end else if (accept) begin
                    // A new select beats a coincident step.
                    index_nxt = i_data_in;
                    cnt_nxt   = '0;
                end else if (term) begin
                    cnt_nxt = '0;
                    if (i_mode == MODE_UP) begin
                        index_nxt = index + SEL_W'(1);
                        wrap_nxt  = (index == {SEL_W{1'b1}});
                    end else begin
                        index_nxt = index - SEL_W'(1);
                        wrap_nxt  = (index == '0);
                    end
                end else begin
                    cnt_nxt = cnt + DWELL_W'(1);
                end
            end
            FREEZE: begin
                if (i_mode == MODE_DIRECT) begin
                    state_nxt = DECODE;
                end else if (scan_mode) begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        decoder_out = '0;
        for (int i = 0; i < OUT_W; i++) begin
            decoder_out[i] = en_r && (state != IDLE) && (index == SEL_W'(i));
        end
    end

    assign o_index       = index;
    assign o_data_in_rdy = rdy;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Scoreboard bench for decoder_n_scan (SEL_W=3): per-cycle expectations are queued
// when stimulus is driven and popped once the following edge has been taken.
module tb_decoder_n_scan;

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] idx;
        logic       wrap;
        logic       rdy;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] data;
    logic       vld;
    logic       rdy;
    logic       en;
    logic [1:0] mode;
    logic [7:0] dwell;
    logic [7:0] decoder_out;
    logic [2:0] o_index;
    logic       o_wrap;

    obs_t cur;
    obs_t exp_v;
    obs_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    decoder_n_scan #(.SEL_W(3), .DWELL_W(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_in    (data),
        .i_data_in_vld(vld),
        .o_data_in_rdy(rdy),
        .i_data_in_en (en),
        .i_mode       (mode),
        .i_dwell      (dwell),
        .decoder_out  (decoder_out),
        .o_index      (o_index),
        .o_wrap       (o_wrap)
    );

    always #5 clk = ~clk;

    assign cur = {decoder_out, o_index, o_wrap, rdy};

    function automatic obs_t mk(int idx, bit on, bit w, bit r);
        obs_t m;
        m.idx  = 3'(idx);
        m.out  = on ? (8'd1 << m.idx) : 8'd0;
        m.wrap = w;
        m.rdy  = r;
        return m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; vld = 1'b0; mode = 2'b00; dwell = 8'd0; data = 3'd0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(0, 0, 0, 0));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
        rst_n = 1'b1;
        sb.push_back(mk(0, 0, 0, 1));
        @(posedge clk); #1;
        exp_v = sb.pop_front(); n_cmp++;
        if (cur !== exp_v) begin
            n_err++;
            $display("FAIL reset_release: got %h required %h", cur, exp_v);
        end
    endtask

    task automatic test_direct();
        int sel[3] = '{5, 7, 7};
        mode = 2'b00;
        for (int k = 0; k < 3; k++) begin
            vld  = (k < 2);
            data = 3'(sel[k]);
            sb.push_back(mk(sel[k], 1, 0, 1));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL direct[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
    endtask

    task automatic test_enable();
        bit en_seq[6] = '{1, 0, 0, 0, 1, 1};
        mode = 2'b00;
        for (int k = 0; k < 6; k++) begin
            vld  = (k == 0);
            data = 3'd2;
            en   = en_seq[k];
            sb.push_back(mk(2, en_seq[k], 0, 1));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL enable[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
    endtask

    task automatic test_scan_up();
        int exp_idx[8] = '{6, 6, 6, 7, 7, 0, 0, 1};
        for (int k = 0; k < 8; k++) begin
            vld   = (k == 0);
            data  = 3'd6;
            mode  = (k == 0) ? 2'b00 : 2'b01;
            dwell = 8'd2;
            sb.push_back(mk(exp_idx[k], 1, (k == 5), 1));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL scan_up[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
    endtask

    task automatic test_scan_down();
        int exp_idx[5] = '{1, 1, 0, 7, 6};
        for (int k = 0; k < 5; k++) begin
            vld   = (k == 0);
            data  = 3'd1;
            mode  = (k == 0) ? 2'b00 : 2'b10;
            dwell = 8'd0;
            sb.push_back(mk(exp_idx[k], 1, (k == 3), 1));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL scan_down[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
    endtask

    task automatic test_collision_freeze();
        // cycle 0 collision, 1 count once, 2..6 freeze, 7..9 resume from held count
        int exp_idx[10] = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 4};
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                vld = 1'b1; data = 3'd3; mode = 2'b10; dwell = 8'd0;
            end else if (k == 1) begin
                vld = 1'b0; mode = 2'b01; dwell = 8'd3;
            end else if (k <= 6) begin
                vld = (k > 2); data = 3'd0; mode = 2'b11;
            end else begin
                vld = 1'b0; mode = 2'b01;
            end
            sb.push_back(mk(exp_idx[k], 1, 0, !(k >= 2 && k <= 6)));
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL collision_freeze[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        obs_t exp_seq[4];
        exp_seq[0] = mk(0, 0, 0, 0);
        exp_seq[1] = mk(0, 0, 0, 1);
        exp_seq[2] = mk(0, 1, 0, 1);
        exp_seq[3] = mk(0, 1, 0, 1);
        vld = 1'b0; dwell = 8'd3;
        for (int k = 0; k < 4; k++) begin
            rst_n = (k != 0);
            mode  = (k == 1) ? 2'b11 : 2'b01;
            sb.push_back(exp_seq[k]);
            @(posedge clk); #1;
            exp_v = sb.pop_front(); n_cmp++;
            if (cur !== exp_v) begin
                n_err++;
                $display("FAIL reset_mid_scan[%0d]: got %h required %h", k, cur, exp_v);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_direct();
        test_enable();
        test_scan_up();
        test_scan_down();
        test_collision_freeze();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_n_scan.md
Name: decoder_n_scan

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Successor to the combinational 3-to-8 decoder with enable.
- Adds a valid/ready select handshake, and an auto-scan mode that walks a single '1' across the output with programmable dwell, in either direction.
- Freeze mode holds the current state.
- Drives one-hot strobes (LED/column select, channel enables) in the training/demo designs.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived, not overridable).
- DWELL_W, 8, width of the dwell-count input.

Ports:
- i_clk  in  1  rising-edge clock.
- i_rst_n  in  1  synchronous reset, active-low.
- i_data_in  in  SEL_W  select index.
- i_data_in_vld  in  1  select valid.
- o_data_in_rdy  out  1  select ready.
- i_data_in_en  in  1  output enable; 0 forces decoder_out to zero.
- i_mode  in  2  00 direct, 01 scan-up, 10 scan-down, 11 freeze.
- i_dwell  in  DWELL_W  cycles per scan position; 0 is treated as 1.
- decoder_out  out  OUT_W  registered one-hot output.
- o_index  out  SEL_W  current registered index.
- o_wrap  out  1  one-cycle pulse on scan wrap-around.

Behaviour:
- One clock. Reset is synchronous and active-low; all state is updated on the rising edge of i_clk.
- Reset (i_rst_n=0 at an edge), applied next edge:
  - state=IDLE, index=0, dwell counter=0.
  - decoder_out=0, o_index=0, o_wrap=0, o_data_in_rdy=0.
  - Reset mid-scan or mid-freeze aborts immediately; no wrap pulse.
- o_data_in_rdy is registered. It is 1 in IDLE, DECODE and SCAN, and 0 in FREEZE and during reset. Accept = i_data_in_vld & o_data_in_rdy.
- decoder_out = (1 << index) when state != IDLE and the enable register = 1; otherwise 0.
  - Enable register = i_data_in_en sampled each cycle, so enable takes effect with 1-cycle latency.
  - Enable low does not stop the index or counter.
- States:
  - IDLE:
    - Accept with mode 00 -> DECODE; index=i_data_in.
    - Mode 01/10 -> SCAN; index=i_data_in if accepted that cycle, else 0.
    - Mode 11 -> stay in IDLE.
  - DECODE:
    - Accept loads index=i_data_in. Output updates the cycle after the accept edge (1-cycle latency).
    - Mode 01/10 -> SCAN from the current index, counter=0.
    - Mode 11 -> FREEZE.
  - SCAN:
    - The counter increments each cycle.
    - Terminal count is counter >= max(i_dwell,1)-1, evaluated against the live i_dwell. At terminal count, counter=0 and index steps +1 (mode 01) or -1 (mode 10), modulo OUT_W.
    - A direction change takes effect at the next terminal count; the counter is not cleared.
    - Mode 00 -> DECODE; index held, counter=0.
    - Mode 11 -> FREEZE.
  - FREEZE:
    - Index, counter and output are held; rdy=0.
    - Exit on mode 00 -> DECODE, or mode 01/10 -> SCAN. The counter resumes from its held value.
- o_wrap: registered, high for exactly the one cycle in which o_index first shows the wrapped value (OUT_W-1 -> 0 up, 0 -> OUT_W-1 down). Never asserted outside SCAN stepping.
- Simultaneous accept and terminal count in SCAN: accept wins. index=i_data_in, counter=0, no step, no o_wrap.
- i_dwell=0 or 1: step every cycle.
- Index arithmetic is SEL_W bits wide and wraps naturally.
- decoder_out is never multi-hot.

Test Plan:
- Reset then direct decode (SEL_W=3): i_rst_n=0 for 2 cycles -> decoder_out=0, rdy=0. Release, mode=00, en=1, accept index 5 -> decoder_out=8'b0010_0000 one cycle after accept. Then accept 7 -> 8'h80.
- Enable gating: decode index 2, drop en for 3 cycles -> decoder_out=0 for 3 cycles starting one cycle later. Restore -> 8'h04, o_index stays 2 throughout.
- Scan-up wrap: mode=01, dwell=2, start index 6 -> 6,6,7,7,0,0,1. o_wrap=1 only on the first cycle showing index 0.
- Scan-down with dwell=0: start index 1, mode=10 -> 1,0,7,6 on consecutive cycles. o_wrap pulses on the first cycle showing index 7.
- Collision and freeze:
  - In SCAN, accept index 3 on a terminal-count cycle -> index=3, no step, no o_wrap.
  - Then mode=11 for 5 cycles -> output held at 8'h08 and rdy=0.
  - Mode back to 01 -> scan resumes from the held counter.
- Reset mid-scan: assert i_rst_n=0 while index=4 in SCAN -> next edge decoder_out=0, o_index=0, o_wrap=0, state IDLE.
